// File: rtl/boron_pkg.sv
// Shared widths, nominal core latency and arbiter FSM encoding.
package boron_pkg;

  localparam int unsigned TEXT_W       = 64;
  localparam int unsigned KEY_W        = 80;
  localparam int unsigned CORE_NOM_LAT = 27;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/boron_rr_picker.sv
// Round-robin priority search: first valid requester at or above the
// pointer, wrapping to the lowest valid one below it.
module boron_rr_picker #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req_valid,
  input  logic [ID_W-1:0] i_rr_ptr,
  output logic [ID_W-1:0] o_grant,
  output logic            o_any_valid
);

  logic            w_hi_found;
  logic [ID_W-1:0] w_hi_idx;
  logic [ID_W-1:0] w_lo_idx;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    w_hi_found  = 1'b0;
    w_hi_idx    = '0;
    w_lo_idx    = '0;
    o_any_valid = 1'b0;
    for (int unsigned j = NREQ; j > 0; j--) begin
      if (i_req_valid[j-1]) begin
        o_any_valid = 1'b1;
        w_lo_idx    = ID_W'(j-1);
        if (ID_W'(j-1) >= i_rr_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = ID_W'(j-1);
        end
      end
    end
    o_grant = w_hi_found ? w_hi_idx : w_lo_idx;
  end

endmodule

// File: rtl/boron_req_arbiter.sv
// Shares one Boron core among NREQ requesters: round-robin accept, start
// pulse, completion/timeout detection, tagged valid/ready response.
module boron_req_arbiter
  import boron_pkg::*;
#(
  parameter  int unsigned NREQ    = 4,
  parameter  int unsigned TIMEOUT = 63,
  localparam int unsigned ID_W    = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [TEXT_W*NREQ-1:0]  req_text,
  input  logic [KEY_W*NREQ-1:0]   req_key,
  output logic [NREQ-1:0]         req_ready,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [TEXT_W-1:0]       resp_text,
  output logic                    resp_err,
  output logic                    core_start,
  output logic [TEXT_W-1:0]       core_text,
  output logic [KEY_W-1:0]        core_key,
  input  logic                    core_fin,
  input  logic [TEXT_W-1:0]       core_cipher
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_fin_q;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [NREQ-1:0]   r_req_ready;
  logic              r_core_start;
  logic [TEXT_W-1:0] r_core_text;
  logic [KEY_W-1:0]  r_core_key;
  logic              r_resp_valid;
  logic [ID_W-1:0]   r_resp_id;
  logic [TEXT_W-1:0] r_resp_text;
  logic              r_resp_err;

  logic              w_fin_rise;
  logic [ID_W-1:0]   w_grant;
  logic              w_any_valid;
  logic [TEXT_W-1:0] w_text_sel;
  logic [KEY_W-1:0]  w_key_sel;
  logic [NREQ-1:0]   w_req_ready_nxt;
  logic              w_core_start_nxt;
  logic              w_resp_valid_nxt;
  logic              w_grant_load;
  logic              w_done_ok;
  logic              w_done_to;
  logic              w_handshake;

  assign w_fin_rise = core_fin & ~r_fin_q;

  boron_rr_picker #(.NREQ(NREQ)) u_picker (
    .i_req_valid (req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_any_valid (w_any_valid)
  );

  // Select the granted requester's plaintext and key slices.
  always_comb begin
    w_text_sel = '0;
    w_key_sel  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant == ID_W'(i)) begin
        w_text_sel = req_text[i*TEXT_W +: TEXT_W];
        w_key_sel  = req_key[i*KEY_W +: KEY_W];
      end
    end
  end

  // Next state plus next values of the registered strobes.
  always_comb begin
    w_state_nxt      = r_state;
    w_req_ready_nxt  = '0;
    w_core_start_nxt = 1'b0;
    w_resp_valid_nxt = 1'b0;
    w_grant_load     = 1'b0;
    w_done_ok        = 1'b0;
    w_done_to        = 1'b0;
    w_handshake      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any_valid) begin
          w_req_ready_nxt = {{(NREQ-1){1'b0}}, 1'b1} << w_grant;
          w_grant_load    = 1'b1;
          w_state_nxt     = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        w_core_start_nxt = 1'b1;
        w_state_nxt      = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_fin_rise) begin
          w_done_ok        = 1'b1;
          w_resp_valid_nxt = 1'b1;
          w_state_nxt      = ST_RESP;
        end else if (r_wait_cnt == CNT_W'(TIMEOUT)) begin
          w_done_to        = 1'b1;
          w_resp_valid_nxt = 1'b1;
          w_state_nxt      = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_handshake = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_resp_valid_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath, strobes, timeout counter and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fin_q      <= 1'b0;
      r_rr_ptr     <= '0;
      r_wait_cnt   <= '0;
      r_req_ready  <= '0;
      r_core_start <= 1'b0;
      r_core_text  <= '0;
      r_core_key   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_text  <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_fin_q      <= core_fin;
      r_req_ready  <= w_req_ready_nxt;
      r_core_start <= w_core_start_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      if (w_grant_load) begin
        r_core_text <= w_text_sel;
        r_core_key  <= w_key_sel;
        r_resp_id   <= w_grant;
      end
      if (r_state == ST_LAUNCH)    r_wait_cnt <= '0;
      else if (r_state == ST_WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
      if (w_done_ok) begin
        r_resp_text <= core_cipher;
        r_resp_err  <= 1'b0;
      end else if (w_done_to) begin
        r_resp_text <= '0;
        r_resp_err  <= 1'b1;
      end
      if (w_handshake)
        r_rr_ptr <= (r_resp_id == ID_W'(NREQ-1)) ? '0 : r_resp_id + 1'b1;
    end
  end

  assign req_ready  = r_req_ready;
  assign core_start = r_core_start;
  assign core_text  = r_core_text;
  assign core_key   = r_core_key;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_text  = r_resp_text;
  assign resp_err   = r_resp_err;

endmodule

// File: doc/boron_req_arbiter.md
Name: boron_req_arbiter

Overview:
- Shares one Boron encryption core (Boron_Cntrl plus round datapath) among NREQ independent requesters.
- Each request carries one 64-bit plaintext and one 80-bit key. The block arbitrates round-robin, accepts one request at a time and pulses the core start.
- It detects core completion or a timeout, then returns the ciphertext tagged with the requester ID over a valid/ready response channel.
- Sits between the system-side requesters and the core's start/fin interface. Exactly one encryption is in flight at any time.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 63, WAIT-state cycle limit before aborting with an error (must exceed nominal core latency of 27).
- ID_W, clog2(NREQ), localparam, requester ID width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  NREQ  per-requester request pending.
- req_text  in  64*NREQ  plaintext; slice i belongs to requester i.
- req_key  in  80*NREQ  key; slice i belongs to requester i.
- req_ready  out  NREQ  one-hot accept pulse.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumer ready.
- resp_id  out  ID_W  requester that owns the response.
- resp_text  out  64  ciphertext (0 when resp_err=1).
- resp_err  out  1  timeout abort flag.
- core_start  out  1  one-cycle start pulse to the core.
- core_text  out  64  plaintext to the core.
- core_key  out  80  key to the core.
- core_fin  in  1  core done level (rises once per operation, held until next start).
- core_cipher  in  64  core result, valid when core_fin is high.

Behaviour:
- Reset (async, reset=0), all outputs and registers cleared:
  - req_ready=0, resp_valid=0, resp_id=0, resp_text=0, resp_err=0.
  - core_start=0, core_text=0, core_key=0.
  - State=IDLE, rr_ptr=0, wait_cnt=0, fin_q=0.
- Edge detection: fin_q registers core_fin every cycle. fin_rise = core_fin & ~fin_q. Only fin_rise counts as completion; a stale high fin from the previous operation is ignored.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If any req_valid, select g = first set bit searching from rr_ptr upward, wrapping modulo NREQ.
  - Same cycle: req_ready[g]=1 (registered output, so visible for exactly one cycle). Latch req_text[g] and req_key[g] into core_text and core_key. Latch g into resp_id. Go to LAUNCH.
  - With no req_valid, stay in IDLE with all strobes 0.
- LAUNCH:
  - core_start=1 for exactly this cycle. wait_cnt=0. Go to WAIT.
- WAIT:
  - core_start=0. wait_cnt increments each cycle.
  - On fin_rise: resp_text=core_cipher, resp_err=0, go to RESP.
  - Else, when wait_cnt==TIMEOUT: resp_text=0, resp_err=1, go to RESP.
  - fin_rise and timeout in the same cycle: fin_rise wins.
- RESP:
  - resp_valid=1, and resp_id/resp_text/resp_err held stable until resp_valid&resp_ready.
  - On handshake: resp_valid=0, rr_ptr=(resp_id+1) mod NREQ, go to IDLE.
- core_text and core_key stay constant from latch until the next grant; the core samples them during Round.
- req_ready is never asserted outside IDLE. New requests wait; requesters hold req_valid and their data stable until accepted.
- Latency, accept cycle = T:
  - core_start at T+1.
  - Nominal core fin rise at T+28; resp_valid at T+29.
  - Next grant no earlier than the cycle after the response handshake.
- Reset mid-operation: immediate abort, no response emitted, in-flight request lost. The core is reset separately by the system.
- Fairness: with all requesters continuously valid, the grant order is 0,1,2,...,NREQ-1,0,...

Decomposition:
- boron_pkg holds:
  - TEXT_W=64, KEY_W=80.
  - CORE_NOM_LAT=27.
  - FSM state encoding (2-bit IDLE/LAUNCH/WAIT/RESP).
- Sub-module boron_rr_picker: combinational, inputs req_valid and rr_ptr, outputs grant index and any_valid. This keeps the wrap-around priority search isolated and unit-testable.

Test Plan:
- Bench core model: a stub that raises fin 26 cycles after start with cipher = text ^ key[63:0].
- Single request: req_valid[2]=1, text=64'h0123456789ABCDEF, key=80'h0 -> req_ready[2] pulses once; core_start pulses one cycle later; resp_valid with resp_id=2, resp_text=64'h0123456789ABCDEF, resp_err=0.
- Simultaneous requests 1 and 3 after reset -> 1 served first, then 3. rr_ptr then =0, so a new req on 0 beats a pending req on 1.
- All four continuously valid for 8 operations -> resp_id sequence 0,1,2,3,0,1,2,3, each with the correct text^key.
- Backpressure: resp_ready=0 for 10 cycles in RESP -> resp_valid/id/text stable throughout; no req_ready; completes on the first cycle resp_ready=1.
- Timeout: stub never raises fin -> resp_valid with resp_err=1 and resp_text=0, exactly TIMEOUT+1 cycles after core_start. A stale fin held high from the previous op must not end WAIT early.
- Reset asserted mid-WAIT -> all outputs 0 asynchronously; after release, a new req on 0 is granted first with no spurious response.
